keypad_scan_fifo: RTL and testbench



---
 rtl/keypad_scan_fifo.sv | 210 +++++++++++++++++++++
 tb/tb_keypad_scan_fifo.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_fifo.sv
// Matrix keypad front end: one-hot column scan, two-flop row sync, single-key
// press/release debounce and a small key-code FIFO with a valid/ready consumer port.
module keypad_scan_fifo #(
    parameter int unsigned N_COLS         = 4,
    parameter int unsigned N_ROWS         = 4,
    parameter int unsigned SCAN_DIV       = 8,
    parameter int unsigned DEBOUNCE_SCANS = 3,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned CODE_W         = $clog2(N_ROWS * N_COLS)
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic [N_COLS-1:0]             col,
    input  logic [N_ROWS-1:0]             fil,
    output logic [CODE_W-1:0]             key_code,
    output logic                          key_valid,
    input  logic                          key_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int unsigned COL_W = $clog2(N_COLS);
    localparam int unsigned ROW_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam int unsigned DW_W  = $clog2(SCAN_DIV);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {StIdle, StConfirm, StHeld} state_t;

    logic [DW_W-1:0]   r_dwell;
    logic [N_COLS-1:0] r_col;
    logic [COL_W-1:0]  r_col_idx;
    logic [N_ROWS-1:0] r_sync1;
    logic [N_ROWS-1:0] r_sync2;
    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [COL_W-1:0]  r_cap_col;
    logic [ROW_W-1:0]  r_cap_row;
    logic [CODE_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr;
    logic [PTR_W-1:0]  r_rd;
    logic [LVL_W-1:0]  r_level;
    logic              r_key_valid;
    logic              r_overflow;

    logic              w_sample;
    logic              w_on_cap;
    logic              w_cap_hit;
    logic [ROW_W-1:0]  w_low_row;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_cnt_done;
    logic              w_push;
    logic [CODE_W-1:0] w_push_code;
    logic              w_pop;
    logic              w_full;
    logic              w_wr_en;
    logic [LVL_W-1:0]  w_level_next;

    function automatic logic [CODE_W-1:0] f_code(input logic [ROW_W-1:0] row,
                                                 input logic [COL_W-1:0] c);
        return CODE_W'(32'(row) * N_COLS + 32'(c));
    endfunction

    assign col        = r_col;
    assign key_code   = r_mem[r_rd];
    assign key_valid  = r_key_valid;
    assign fifo_level = r_level;
    assign overflow   = r_overflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dwell   <= '0;
            r_col     <= N_COLS'(1);
            r_col_idx <= '0;
            r_sync1   <= '0;
            r_sync2   <= '0;
        end else begin
            r_sync1 <= fil;
            r_sync2 <= r_sync1;
            if (r_dwell == DW_W'(SCAN_DIV - 1)) begin
                r_dwell   <= '0;
                r_col     <= {r_col[N_COLS-2:0], r_col[N_COLS-1]};
                r_col_idx <= (r_col_idx == COL_W'(N_COLS - 1)) ? '0 : r_col_idx + COL_W'(1);
            end else begin
                r_dwell <= r_dwell + DW_W'(1);
            end
        end
    end

    assign w_sample   = (r_dwell == DW_W'(SCAN_DIV - 1));
    assign w_on_cap   = w_sample && (r_col_idx == r_cap_col);
    assign w_cap_hit  = r_sync2[r_cap_row];
    assign w_cnt_inc  = r_cnt + CNT_W'(1);
    assign w_cnt_done = (w_cnt_inc >= CNT_W'(DEBOUNCE_SCANS));

    // Lowest pressed row wins when several rows are active in one column.
    always_comb begin
        w_low_row = '0;
        for (int i = N_ROWS - 1; i >= 0; i--) begin
            if (r_sync2[i]) w_low_row = ROW_W'(i);
        end
    end

    always_comb begin
        w_push      = 1'b0;
        w_push_code = f_code(r_cap_row, r_cap_col);
        if (w_sample) begin
            unique case (r_state)
                StIdle: begin
                    if ((r_sync2 != '0) && (DEBOUNCE_SCANS == 1)) begin
                        w_push      = 1'b1;
                        w_push_code = f_code(w_low_row, r_col_idx);
                    end
                end
                StConfirm: w_push = w_on_cap && w_cap_hit && w_cnt_done;
                default:   w_push = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_cap_col <= '0;
            r_cap_row <= '0;
        end else if (w_sample) begin
            unique case (r_state)
                StIdle: begin
                    if (r_sync2 != '0) begin
                        r_cap_col <= r_col_idx;
                        r_cap_row <= w_low_row;
                        if (DEBOUNCE_SCANS == 1) begin
                            r_state <= StHeld;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= StConfirm;
                            r_cnt   <= CNT_W'(1);
                        end
                    end
                end
                StConfirm: begin
                    if (w_on_cap) begin
                        if (!w_cap_hit) begin
                            r_state <= StIdle;
                            r_cnt   <= '0;
                        end else if (w_cnt_done) begin
                            r_state <= StHeld;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end
                StHeld: begin
                    // Any pressed sample restarts the release count.
                    if (w_on_cap) begin
                        if (w_cap_hit) begin
                            r_cnt <= '0;
                        end else if (w_cnt_done) begin
                            r_state <= StIdle;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign w_pop   = r_key_valid && key_ready;
    assign w_full  = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_wr_en = w_push && (!w_full || w_pop);

    always_comb begin
        w_level_next = r_level;
        if (w_wr_en && !w_pop) begin
            w_level_next = r_level + LVL_W'(1);
        end else if (!w_wr_en && w_pop) begin
            w_level_next = r_level - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr        <= '0;
            r_rd        <= '0;
            r_level     <= '0;
            r_key_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_mem[r_wr] <= w_push_code;
                r_wr        <= r_wr + PTR_W'(1);
            end
            if (w_pop) r_rd <= r_rd + PTR_W'(1);
            r_level     <= w_level_next;
            r_key_valid <= (w_level_next != '0);
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Bench for keypad_scan_fifo: directed keypad scenarios plus random key/ready traffic,
// all checked every cycle against a queue-based model of scan, debounce and FIFO.
module tb_keypad_scan_fifo;

    localparam int NC  = 4;
    localparam int NR  = 4;
    localparam int SD  = 8;
    localparam int DB  = 3;
    localparam int FD  = 4;
    localparam int ROT = NC * SD;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NC-1:0] col;
    logic [NR-1:0] fil;
    logic [3:0]    key_code;
    logic          key_valid;
    logic          key_ready = 1'b0;
    logic [2:0]    fifo_level;
    logic          overflow;
    logic [15:0]   keys = '0;

    int n_checks = 0;
    int n_err    = 0;

    keypad_scan_fifo #(
        .N_COLS(NC), .N_ROWS(NR), .SCAN_DIV(SD), .DEBOUNCE_SCANS(DB), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst), .col(col), .fil(fil), .key_code(key_code),
        .key_valid(key_valid), .key_ready(key_ready), .fifo_level(fifo_level),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key connects its column drive to its row.
    always_comb begin
        fil = '0;
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                if (keys[r*NC+c] && col[c]) fil[r] = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: cycle count since reset gives the column, a 2-deep history gives
    // the synchronised rows, one locked key is debounced in visits, and a queue is the FIFO.
    bit   m_active = 0;
    int   m_cyc;
    logic [NR-1:0] m_h1, m_h2;
    int   m_q[$];
    bit   m_ovf;
    int   m_key;
    bit   m_held;
    int   m_run;
    int   popped[$];
    int   valid_cycles;

    always @(posedge clk) begin
        int  c, pre, code;
        bit  accept, pressed, pop;
        if (rst) begin
            m_active = 1;
            m_cyc = 0; m_h1 = '0; m_h2 = '0;
            m_q.delete(); m_ovf = 0;
            m_key = -1; m_held = 0; m_run = 0;
        end else if (m_active) begin
            if (key_valid) valid_cycles++;
            if (key_valid && key_ready) popped.push_back(int'(key_code));
            accept = 0; code = 0;
            if (m_cyc % SD == SD - 1) begin
                c = (m_cyc / SD) % NC;
                if (m_key < 0) begin
                    if (m_h2 != '0) begin
                        for (int r = NR - 1; r >= 0; r--) if (m_h2[r]) m_key = r * NC + c;
                        m_held = 0; m_run = 1;
                        if (DB == 1) begin accept = 1; code = m_key; m_held = 1; m_run = 0; end
                    end
                end else if (c == m_key % NC) begin
                    pressed = m_h2[m_key / NC];
                    if (!m_held) begin
                        if (pressed) begin
                            m_run++;
                            if (m_run == DB) begin accept = 1; code = m_key; m_held = 1; m_run = 0; end
                        end else begin
                            m_key = -1;
                        end
                    end else if (!pressed) begin
                        m_run++;
                        if (m_run == DB) m_key = -1;
                    end else begin
                        m_run = 0;
                    end
                end
            end
            pre = m_q.size();
            pop = key_ready && (pre > 0);
            if (pop) void'(m_q.pop_front());
            if (accept) begin
                if (pre < FD || pop) m_q.push_back(code);
                else m_ovf = 1;
            end
            m_h2 = m_h1; m_h1 = fil;
            m_cyc++;
        end
    end

    always @(negedge clk) begin
        if (m_active) begin
            chk("col", col, 32'(1) << ((m_cyc / SD) % NC));
            chk("key_valid", key_valid, m_q.size() != 0);
            chk("fifo_level", fifo_level, m_q.size());
            chk("overflow", overflow, m_ovf);
            if (m_q.size() != 0) chk("key_code", key_code, m_q[0]);
        end
    end

    task automatic rot(input int n);
        repeat (n * ROT) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain(input int n);
        key_ready = 1'b1;
        repeat (n) @(negedge clk);
        key_ready = 1'b0;
    endtask

    task automatic tap(input int code);
        keys = 16'(1) << code; rot(3);
        keys = '0;             rot(3);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_col", col, 1);
        chk("rst_valid", key_valid, 0);
        chk("rst_code", key_code, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ovf", overflow, 0);

        // Long hold with consumer ready: exactly one code 9, valid for one cycle.
        key_ready = 1'b1; popped.delete(); valid_cycles = 0;
        keys = 16'(1) << 9; rot(10);
        keys = '0;          rot(3);
        key_ready = 1'b0;
        chk("hold_npop", popped.size(), 1);
        if (popped.size() > 0) chk("hold_code", popped[0], 9);
        chk("hold_vcyc", valid_cycles, 1);

        // Bounce: two hits, a miss, then three hits.
        do_reset(); key_ready = 1'b1; popped.delete();
        keys = 16'(1) << 9; rot(2);
        keys = '0;          rot(1);
        keys = 16'(1) << 9; rot(2);
        chk("bounce_early", popped.size(), 0);
        rot(1);
        chk("bounce_npop", popped.size(), 1);
        if (popped.size() > 0) chk("bounce_code", popped[0], 9);
        keys = '0; rot(3);
        key_ready = 1'b0;

        // Release and re-press queue two codes.
        do_reset(); popped.delete();
        tap(9);
        keys = 16'(1) << 9; rot(3);
        chk("repress_level", fifo_level, 2);
        keys = '0; rot(3);
        drain(4);
        chk("repress_npop", popped.size(), 2);
        if (popped.size() == 2) begin
            chk("repress_c0", popped[0], 9);
            chk("repress_c1", popped[1], 9);
        end

        // Overflow: five keys into a four-deep queue.
        do_reset(); popped.delete();
        for (int k = 0; k < 5; k++) tap(k);
        chk("ovf_level", fifo_level, 4);
        chk("ovf_flag", overflow, 1);
        drain(6);
        chk("ovf_npop", popped.size(), 4);
        if (popped.size() == 4)
            for (int k = 0; k < 4; k++) chk("ovf_order", popped[k], k);
        chk("ovf_sticky", overflow, 1);

        // Full FIFO with push and pop on the same edge.
        do_reset(); popped.delete();
        for (int k = 0; k < 4; k++) tap(k);
        chk("full_level", fifo_level, 4);
        keys = 16'(1) << 5;
        rot(2);
        repeat (15) @(negedge clk);
        key_ready = 1'b1;
        @(negedge clk);
        key_ready = 1'b0;
        chk("pp_ovf", overflow, 0);
        chk("pp_level", fifo_level, 4);
        repeat (ROT - 16) @(negedge clk);
        keys = '0; rot(3);
        popped.delete();
        drain(6);
        chk("pp_npop", popped.size(), 4);
        if (popped.size() == 4) begin
            chk("pp_c0", popped[0], 1);
            chk("pp_c1", popped[1], 2);
            chk("pp_c2", popped[2], 3);
            chk("pp_c3", popped[3], 5);
        end

        // Reset while confirming: debounce must restart from scratch.
        do_reset();
        keys = 16'(1) << 9; rot(2);
        do_reset();
        chk("midrst_col", col, 1);
        chk("midrst_level", fifo_level, 0);
        chk("midrst_valid", key_valid, 0);
        rot(2);
        chk("midrst_early", fifo_level, 0);
        rot(1);
        chk("midrst_level1", fifo_level, 1);
        chk("midrst_code", key_code, 9);
        keys = '0; rot(3);

        // Random keypad activity and consumer back-pressure.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 3))
                    0, 1: keys = '0;
                    2:    keys = 16'(1) << $urandom_range(0, 15);
                    default: keys = 16'($urandom);
                endcase
            end
            key_ready = ($urandom_range(0, 2) == 0);
            if (i == 2000) rst = 1'b1;
            else           rst = 1'b0;
            @(negedge clk);
        end
        rst = 1'b0; keys = '0; key_ready = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
